// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-sequence detector. A shift register and fill counter
// compare the last len_r accepted bits against a loaded pattern.
module seq_detect_prog #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy_fill
);
    logic [MAX_LEN-1:0] pat_r, hist, hist_n, mask;
    logic [LEN_W-1:0]   len_r, fill, fill_n, len_clamp;
    logic               accept, hit;

    always_comb begin
        accept    = din_valid && !cfg_load;
        hist_n    = {hist[MAX_LEN-2:0], din};
        fill_n    = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
        len_clamp = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
        mask      = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len_r));
        // Only the low len_r bits take part; older history is ignored.
        hit = accept && (len_r != '0) && (fill_n >= len_r) &&
              ((hist_n & mask) == (pat_r & mask));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_r     <= '0;
            len_r     <= '0;
            hist      <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            match <= 1'b0;
            if (cfg_load) begin
                pat_r <= cfg_pat;
                len_r <= len_clamp;
                hist  <= '0;
                fill  <= '0;
            end else if (accept) begin
                match <= hit;
                if (hit && !cfg_overlap) begin
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= hist_n;
                    fill <= fill_n;
                end
            end
            // Clear beats a same-cycle hit; the counter never wraps.
            if (cnt_clr)
                match_cnt <= '0;
            else if (hit && (match_cnt != {CNT_W{1'b1}}))
                match_cnt <= match_cnt + 1'b1;
        end
    end

    assign busy_fill = (len_r != '0) && (fill < len_r);
endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations per scenario.
module tb_seq_detect_prog;
    localparam int ML = 8;
    localparam int CW = 2;
    localparam int LW = $clog2(ML + 1);

    logic          clk = 1'b0;
    logic          rst, din, din_valid, cfg_load, cfg_overlap, cnt_clr;
    logic [ML-1:0] cfg_pat;
    logic [LW-1:0] cfg_len;
    logic          match, busy_fill;
    logic [CW-1:0] match_cnt;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    seq_detect_prog #(.MAX_LEN(ML), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match(match), .match_cnt(match_cnt), .busy_fill(busy_fill)
    );

    always #5 clk = ~clk;

    // Reference model: the accepted bits since the last flush, newest at the back.
    bit       mq[$];
    logic [ML-1:0] m_pat;
    int       m_len, m_cnt;
    logic     e_match;

    always @(posedge clk) begin
        bit h;
        h = 0;
        if (rst) begin
            mq.delete(); m_pat = '0; m_len = 0; m_cnt = 0; e_match = 0;
        end else begin
            if (cfg_load) begin
                m_pat = cfg_pat;
                m_len = (int'(cfg_len) > ML) ? ML : int'(cfg_len);
                mq.delete();
            end else if (din_valid) begin
                mq.push_back(din);
                if (mq.size() > ML) void'(mq.pop_front());
                if (m_len != 0 && mq.size() >= m_len) begin
                    h = 1;
                    for (int k = 0; k < m_len; k++)
                        if (mq[mq.size()-1-k] != m_pat[k]) h = 0;
                end
                if (h && !cfg_overlap) mq.delete();
            end
            e_match = h;
            if (cnt_clr) m_cnt = 0;
            else if (h && m_cnt < (1 << CW) - 1) m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic e_busy;
            e_busy = (m_len != 0) && (mq.size() < m_len);
            n_cmp++;
            if (match !== e_match || int'(match_cnt) != m_cnt || match_cnt !== match_cnt ||
                busy_fill !== e_busy) begin
                n_err++;
                $display("FAIL model t=%0t: got match=%b cnt=%0d busy=%b, want match=%b cnt=%0d busy=%b",
                         $time, match, match_cnt, busy_fill, e_match, m_cnt, e_busy);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic load(input logic [ML-1:0] p, input logic [LW-1:0] l, input logic ov);
        cfg_load = 1; cfg_pat = p; cfg_len = l; cfg_overlap = ov;
        tick();
        cfg_load = 0;
    endtask

    task automatic clr;
        cnt_clr = 1; tick(); cnt_clr = 0;
    endtask

    task automatic send(input logic d);
        din_valid = 1; din = d; tick(); din_valid = 0;
    endtask

    // Sends n bits MSB-first; got[i] is match sampled after bit i.
    task automatic stream(input logic [15:0] bits, input int n, output logic [15:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            send(bits[n-1-i]);
            got[i] = match;
        end
    endtask

    initial begin
        logic [15:0] got;
        logic [4:0]  bz;
        rst = 1; din = 0; din_valid = 0; cfg_load = 0; cfg_overlap = 0; cnt_clr = 0;
        cfg_pat = '0; cfg_len = '0;
        tick();
        rst = 0;
        chk_en = 1;
        chk("reset_match", {31'd0, match}, 0);
        chk("reset_cnt", {30'd0, match_cnt}, 0);
        chk("reset_busy", {31'd0, busy_fill}, 0);

        // Overlapping 1001
        load(8'b1001, 4'd4, 1'b1);
        stream(16'b1001001, 7, got);
        chk("ovl_hits", {16'd0, got}, 32'h0048);
        chk("ovl_cnt", {30'd0, match_cnt}, 2);

        // Non-overlapping 1001
        clr();
        load(8'b1001, 4'd4, 1'b0);
        stream(16'b1001001001, 10, got);
        chk("novl_hits", {16'd0, got}, 32'h0208);
        chk("novl_cnt", {30'd0, match_cnt}, 2);

        // Valid gaps and priming with 110
        clr();
        load(8'b110, 4'd3, 1'b1);
        chk("prime_busy0", {31'd0, busy_fill}, 1);
        got = '0;
        for (int i = 0; i < 5; i++) begin
            din_valid = (i % 2 == 0);
            din = (i == 4) ? 1'b0 : 1'b1;
            tick();
            got[i] = match; bz[i] = busy_fill;
        end
        din_valid = 0;
        chk("gap_hits", {16'd0, got}, 32'h0010);
        chk("gap_busy", {27'd0, bz}, 32'h0F);

        // cfg_load mid-sequence drops the coincident bit
        load(8'b1001, 4'd4, 1'b1);
        stream(16'b100, 3, got);
        cfg_load = 1; din_valid = 1; din = 1; tick();
        cfg_load = 0; din_valid = 0;
        chk("ld_mid_match", {31'd0, match}, 0);
        chk("ld_mid_busy", {31'd0, busy_fill}, 1);
        stream(16'b1001, 4, got);
        chk("ld_after_hits", {16'd0, got}, 32'h0008);

        // Reset mid-sequence wins over a valid bit
        stream(16'b100, 3, got);
        rst = 1; din_valid = 1; din = 1; tick();
        rst = 0; din_valid = 0;
        chk("rst_mid_match", {31'd0, match}, 0);
        chk("rst_mid_cnt", {30'd0, match_cnt}, 0);
        chk("rst_mid_busy", {31'd0, busy_fill}, 0);
        stream(16'b1001, 4, got);
        chk("rst_nohits", {16'd0, got}, 0);

        // Length 0 disables; length 15 clamps to 8
        load(8'b1001, 4'd0, 1'b1);
        stream(16'b100111001, 9, got);
        chk("len0_hits", {16'd0, got}, 0);
        chk("len0_busy", {31'd0, busy_fill}, 0);
        load(8'hA5, 4'd15, 1'b1);
        chk("clamp_busy", {31'd0, busy_fill}, 1);
        stream(16'h00A5, 8, got);
        chk("clamp_hits", {16'd0, got}, 32'h0080);

        // Saturating counter and clear-over-hit
        clr();
        load(8'b1, 4'd1, 1'b1);
        stream(16'b11111, 5, got);
        chk("sat_hits", {16'd0, got}, 32'h001F);
        chk("sat_cnt", {30'd0, match_cnt}, 3);
        cnt_clr = 1; send(1'b1); cnt_clr = 0;
        chk("clr_hit_match", {31'd0, match}, 1);
        chk("clr_hit_cnt", {30'd0, match_cnt}, 0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
